// File: rtl/reg_dump_ctrl_pkg.sv
// Shared definitions for the register-dump controller: the default widths
// and the FSM state encoding.
package reg_dump_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_e;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Streams a range of register-file entries out over a valid/ready port,
// retrying any read that collides with a register-file write.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rf_we,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] last_q;
  logic              handshake;
  logic              at_last;

  assign handshake = o_valid && i_ready;
  assign at_last   = (ptr_q == last_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start) state_d = S_ISSUE;
      S_ISSUE: if (!i_rf_we) state_d = S_CAPT;
      S_CAPT:  state_d = S_OUT;
      S_OUT:   if (handshake) state_d = at_last ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer increment relies on ADDR_W-bit truncation for the 31 -> 0 wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      last_q  <= '0;
      o_data  <= '0;
      o_idx   <= '0;
      o_valid <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            ptr_q  <= i_first;
            last_q <= i_last;
          end
        end
        S_CAPT: begin
          o_data  <= i_rdata;
          o_idx   <= ptr_q;
          o_valid <= 1'b1;
        end
        S_OUT: begin
          if (handshake) begin
            o_valid <= 1'b0;
            if (!at_last) ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_raddr = (state_q == S_IDLE) ? '0 : ptr_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = (state_q == S_DONE);

endmodule
